popcnt_seq: RTL and testbench

//  Multi-cycle population counter for wide vectors. Latches an IN-bit word on a

---
 rtl/popcnt_seq.sv | 167 ++++++++++++++++
 tb/tb_popcnt_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/popcnt_seq.sv
// popcnt_seq: multi-cycle population counter, one SEG-bit segment per cycle.
// Ports: clk, reset (sync, active-high), in_valid/in_ready/in,
//   flush, busy, out_valid/out_ready/out (count of bits equal to ACT).

`ifndef High
`define High 1'b1
`endif
`ifndef Low
`define Low 1'b0
`endif

// Combinational count of bits in a W-bit word equal to ACT.
module cnt_bits #(
  parameter int   W   = 32,
  parameter logic ACT = 1'b1,
  parameter int   CW  = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      if (bits[i] == ACT) cnt = cnt + CW'(1);
    end
  end

endmodule

module popcnt_seq #(
  parameter int   IN  = 256,
  parameter int   SEG = 32,
  parameter logic ACT = `High,
  parameter int   OUT = $clog2(IN) + 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [IN-1:0]  in,
  input  logic           flush,
  output logic           busy,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OUT-1:0] out
);

  localparam int NSEG = (IN + SEG - 1) / SEG;
  localparam int PW   = NSEG * SEG;
  localparam int IDXW = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int CW   = $clog2(SEG + 1);
  localparam logic [IDXW-1:0] LAST = IDXW'(NSEG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   buf_q, buf_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [OUT-1:0]  acc_q, acc_d;
  logic [OUT-1:0]  out_q, out_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q;
  logic            in_ready_q;

  logic [PW-1:0]   pad_in;
  logic [CW-1:0]   seg_cnt;
  logic [OUT-1:0]  acc_sum;

  // Unused high bits of the last segment hold ~ACT so they never count.
  always_comb begin
    pad_in         = {PW{~ACT}};
    pad_in[IN-1:0] = in;
  end

  // The buffer shifts down one segment per RUN cycle,
  // so the current segment is always at the bottom.
  cnt_bits #(
    .W   (SEG),
    .ACT (ACT),
    .CW  (CW)
  ) u_cnt (
    .bits (buf_q[SEG-1:0]),
    .cnt  (seg_cnt)
  );

  assign acc_sum = acc_q + OUT'(seg_cnt);

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          buf_d   = pad_in;
          idx_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_sum;
        buf_d = buf_q >> SEG;
        idx_d = idx_q + IDXW'(1);
        if (idx_q == LAST) begin
          idx_d       = '0;
          out_d       = acc_sum;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    // Abort has priority over every handshake.
    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      idx_d       = '0;
      acc_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= (state_d != IDLE);
      in_ready_q  <= (state_d == IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule

// File: tb/tb_popcnt_seq.sv
// tb_popcnt_seq: table, random and corner-case checks of popcnt_seq
// across several IN/SEG/ACT configurations.
module tb_popcnt_seq;

  localparam int ND = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst  [ND];
  logic         iv   [ND];
  logic         fl   [ND];
  logic         ordy [ND];
  logic [255:0] din  [ND];
  logic         ir   [ND];
  logic         bz   [ND];
  logic         ov   [ND];
  logic [8:0]   dout [ND];

  logic [7:0] o1, o2;
  logic [3:0] o3;
  logic [4:0] o4;

  int cin  [ND] = '{256, 100, 100, 8, 16};
  int cseg [ND] = '{32, 32, 32, 1, 16};
  int cact [ND] = '{1, 1, 0, 1, 0};

  int nchk = 0;
  int nerr = 0;

  popcnt_seq #(.IN(256), .SEG(32), .ACT(1'b1)) u0 (
    .clk(clk), .reset(rst[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .in(din[0]), .flush(fl[0]), .busy(bz[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .out(dout[0])
  );
  popcnt_seq #(.IN(100), .SEG(32), .ACT(1'b1)) u1 (
    .clk(clk), .reset(rst[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .in(din[1][99:0]), .flush(fl[1]), .busy(bz[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .out(o1)
  );
  popcnt_seq #(.IN(100), .SEG(32), .ACT(1'b0)) u2 (
    .clk(clk), .reset(rst[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .in(din[2][99:0]), .flush(fl[2]), .busy(bz[2]), .out_valid(ov[2]),
    .out_ready(ordy[2]), .out(o2)
  );
  popcnt_seq #(.IN(8), .SEG(1), .ACT(1'b1)) u3 (
    .clk(clk), .reset(rst[3]), .in_valid(iv[3]), .in_ready(ir[3]),
    .in(din[3][7:0]), .flush(fl[3]), .busy(bz[3]), .out_valid(ov[3]),
    .out_ready(ordy[3]), .out(o3)
  );
  popcnt_seq #(.IN(16), .SEG(16), .ACT(1'b0)) u4 (
    .clk(clk), .reset(rst[4]), .in_valid(iv[4]), .in_ready(ir[4]),
    .in(din[4][15:0]), .flush(fl[4]), .busy(bz[4]), .out_valid(ov[4]),
    .out_ready(ordy[4]), .out(o4)
  );
  assign dout[1] = {1'b0, o1};
  assign dout[2] = {1'b0, o2};
  assign dout[3] = {5'b0, o3};
  assign dout[4] = {4'b0, o4};

  task automatic chk(input string nm, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: count of bits equal to the active value among the low IN bits.
  function automatic int ref_cnt(input int k, input logic [255:0] w);
    int n = 0;
    for (int i = 0; i < cin[k]; i++)
      if (int'(w[i]) == cact[k]) n++;
    return n;
  endfunction

  function automatic int nseg_of(input int k);
    return (cin[k] + cseg[k] - 1) / cseg[k];
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Accept one word, wait for the result, check latency and value, pop it.
  task automatic xact(input int k, input logic [255:0] w,
                      input int exp, input string nm);
    int cyc;
    @(negedge clk);
    chk({nm, " in_ready"}, ir[k], 1);
    din[k] = w;
    iv[k]  = 1'b1;
    @(negedge clk);
    iv[k]  = 1'b0;
    din[k] = ~w;
    chk({nm, " busy"}, bz[k], 1);
    cyc = 0;
    while (!ov[k] && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, " latency"}, cyc, nseg_of(k));
    chk({nm, " out"}, dout[k], exp);
    ordy[k] = 1'b1;
    @(negedge clk);
    ordy[k] = 1'b0;
    chk({nm, " ov_clr"}, ov[k], 0);
    chk({nm, " idle"}, ir[k], 1);
  endtask

  typedef struct {
    int           k;
    logic [255:0] w;
    int           exp;
    string        nm;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [255:0] w, one;
    int           hold;
    logic [8:0]   held;

    one = 256'd1;
    tbl.push_back('{0, ~256'd0,        256, "t1_ones"});
    tbl.push_back('{0, {32{8'hAA}},    128, "t2_aa"});
    tbl.push_back('{0, 256'd0,         0,   "t2_zero"});
    tbl.push_back('{0, one << 255,     1,   "t2_msb"});
    tbl.push_back('{1, ~256'd0,        100, "t3_ones"});
    tbl.push_back('{2, 256'd0,         100, "t3_low_zero"});
    tbl.push_back('{2, ~256'd0,        0,   "t3_low_ones"});
    tbl.push_back('{3, 256'hA5,        4,   "seg1_a5"});
    tbl.push_back('{4, 256'h00FF,      8,   "eq_low_ff"});

    for (int k = 0; k < ND; k++) begin
      rst[k] = 1'b1; iv[k] = 1'b0; fl[k] = 1'b0;
      ordy[k] = 1'b0; din[k] = '0;
    end
    cycles(2);
    for (int k = 0; k < ND; k++) rst[k] = 1'b0;
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("rst%0d ov", k), ov[k], 0);
      chk($sformatf("rst%0d busy", k), bz[k], 0);
      chk($sformatf("rst%0d rdy", k), ir[k], 1);
      chk($sformatf("rst%0d out", k), dout[k], 0);
    end

    foreach (tbl[i]) xact(tbl[i].k, tbl[i].w, tbl[i].exp, tbl[i].nm);

    for (int n = 0; n < 30; n++) begin
      for (int k = 0; k < ND; k++) begin
        for (int j = 0; j < 8; j++) w[j*32 +: 32] = $urandom;
        xact(k, w, ref_cnt(k, w), $sformatf("rnd%0d", k));
      end
    end

    // Result held with out_ready low; in_valid ignored meanwhile.
    @(negedge clk);
    din[0] = ~256'd0; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    hold = 0;
    while (!ov[0] && hold < 50) begin @(negedge clk); hold++; end
    chk("t4 reach_done", ov[0], 1);
    held = dout[0];
    chk("t4 out", held, 256);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin iv[0] = 1'b1; din[0] = 256'd0; end
      else iv[0] = 1'b0;
      @(negedge clk);
      chk("t4 ov_hold", ov[0], 1);
      chk("t4 out_hold", dout[0], held);
      chk("t4 rdy_low", ir[0], 0);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
    chk("t4 ov_clr", ov[0], 0);
    chk("t4 idle", ir[0], 1);
    chk("t4 busy", bz[0], 0);
    cycles(10);
    chk("t4 no_ghost", ov[0], 0);

    // Reset on the third RUN cycle.
    @(negedge clk);
    din[0] = {32{8'h0F}}; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    cycles(2);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("t5 ov", ov[0], 0);
    chk("t5 busy", bz[0], 0);
    chk("t5 rdy", ir[0], 1);
    cycles(10);
    chk("t5 no_out", ov[0], 0);
    xact(0, ~256'd0, 256, "t5_after");

    // Flush in RUN.
    @(negedge clk);
    din[0] = ~256'd0; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    fl[0] = 1'b1;
    @(negedge clk);
    fl[0] = 1'b0;
    chk("t6run busy", bz[0], 0);
    chk("t6run rdy", ir[0], 1);
    cycles(10);
    chk("t6run no_out", ov[0], 0);

    // Flush in DONE beats out_ready.
    @(negedge clk);
    din[0] = 256'd7; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    hold = 0;
    while (!ov[0] && hold < 50) begin @(negedge clk); hold++; end
    chk("t6done reach", ov[0], 1);
    fl[0] = 1'b1; ordy[0] = 1'b1;
    @(negedge clk);
    fl[0] = 1'b0; ordy[0] = 1'b0;
    chk("t6done ov", ov[0], 0);
    chk("t6done rdy", ir[0], 1);

    // Flush with in_valid in IDLE: no accept.
    @(negedge clk);
    din[0] = ~256'd0; iv[0] = 1'b1; fl[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0; fl[0] = 1'b0;
    chk("t6idle busy", bz[0], 0);
    chk("t6idle rdy", ir[0], 1);
    cycles(10);
    chk("t6idle no_out", ov[0], 0);
    xact(0, {32{8'h81}}, 64, "t6_after");

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
